// File: rtl/miter_mon_pkg.sv
// Shared types and helpers for the miter divergence monitor.
package miter_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MONITOR = 2'd2,
      TRIPPED = 2'd3
   } mon_state_e;

   // Channel-index width; a single channel still gets a 1-bit index.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/miter_mon_prio_enc.sv
// Lowest-set-index priority encoder with an any-set flag (combinational).
module miter_mon_prio_enc
   import miter_mon_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]            vec,
   output logic [idx_w(NUM_CH)-1:0]     idx,
   output logic                         any
);

   localparam int unsigned IDX_W = idx_w(NUM_CH);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = |vec;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (vec[i-1]) idx = IDX_W'(i - 1);
      end
   end

endmodule

// File: rtl/miter_divergence_monitor.sv
// Two-instance miter observation checker: latches the first divergence
// (channel, cycle stamp, both data words) across NUM_CH channels.
// Optional macro MITER_MON_DIVCNT_EN adds the div_cnt divergence counter.
module miter_divergence_monitor
   import miter_mon_pkg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned CH_W          = 32,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        arm,
   input  logic                        clear,
   input  logic [NUM_CH-1:0]           ch_mask,
   input  logic [NUM_CH-1:0]           obs_vld_a,
   input  logic [NUM_CH*CH_W-1:0]      obs_dat_a,
   input  logic [NUM_CH-1:0]           obs_vld_b,
   input  logic [NUM_CH*CH_W-1:0]      obs_dat_b,
   output logic                        busy,
   output logic                        tripped,
   output logic [idx_w(NUM_CH)-1:0]    trip_ch,
   output logic [CNT_W-1:0]            trip_stamp,
   output logic [CH_W-1:0]             trip_dat_a,
   output logic [CH_W-1:0]             trip_dat_b
`ifdef MITER_MON_DIVCNT_EN
   ,
   output logic [CNT_W-1:0]            div_cnt
`endif
);

   localparam int unsigned IDX_W = idx_w(NUM_CH);
   localparam int unsigned SETTLE_INIT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_INIT);

   mon_state_e         state_q, state_d;
   logic [7:0]         settle_cnt;
   logic [CNT_W-1:0]   stamp_cnt;
   logic [NUM_CH-1:0]  div;
   logic [IDX_W-1:0]   first_ch;
   logic               div_any;
   logic [CH_W-1:0]    sel_dat_a, sel_dat_b;

   // Per-channel divergence; data only matters when both sides are valid.
   always_comb begin
      div = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         div[i] = ch_mask[i] &
                  ((obs_vld_a[i] ^ obs_vld_b[i]) |
                   (obs_vld_a[i] & obs_vld_b[i] &
                    (obs_dat_a[i*CH_W +: CH_W] != obs_dat_b[i*CH_W +: CH_W])));
      end
   end

   miter_mon_prio_enc #(.NUM_CH(NUM_CH)) u_prio_enc (
      .vec (div),
      .idx (first_ch),
      .any (div_any)
   );

   // Select the data words of the first diverging channel.
   always_comb begin
      sel_dat_a = '0;
      sel_dat_b = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (first_ch == IDX_W'(i)) begin
            sel_dat_a = obs_dat_a[i*CH_W +: CH_W];
            sel_dat_b = obs_dat_b[i*CH_W +: CH_W];
         end
      end
   end

   // Next-state logic; clear overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arm) state_d = (SETTLE_CYCLES > 0) ? SETTLE : MONITOR;
         SETTLE:  if (settle_cnt == '0) state_d = MONITOR;
         MONITOR: if (div_any) state_d = TRIPPED;
         TRIPPED: state_d = TRIPPED;
         default: state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Counters and first-divergence record.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         settle_cnt <= '0;
         stamp_cnt  <= '0;
         trip_ch    <= '0;
         trip_stamp <= '0;
         trip_dat_a <= '0;
         trip_dat_b <= '0;
`ifdef MITER_MON_DIVCNT_EN
         div_cnt    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  settle_cnt <= SETTLE_LOAD;
                  stamp_cnt  <= '0;
`ifdef MITER_MON_DIVCNT_EN
                  div_cnt    <= '0;
`endif
               end
            end
            SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
               if (stamp_cnt != '1) stamp_cnt <= stamp_cnt + 1'b1;
            end
            MONITOR: begin
               if (stamp_cnt != '1) stamp_cnt <= stamp_cnt + 1'b1;
               if (div_any) begin
                  trip_ch    <= first_ch;
                  trip_stamp <= stamp_cnt;
                  trip_dat_a <= sel_dat_a;
                  trip_dat_b <= sel_dat_b;
               end
`ifdef MITER_MON_DIVCNT_EN
               if (div_any && div_cnt != '1) div_cnt <= div_cnt + 1'b1;
`endif
            end
            TRIPPED: begin
`ifdef MITER_MON_DIVCNT_EN
               if (div_any && div_cnt != '1) div_cnt <= div_cnt + 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state_q == SETTLE) || (state_q == MONITOR);
   assign tripped = (state_q == TRIPPED);

endmodule

// File: tb/tb_miter_divergence_monitor.sv
// Scoreboard bench for miter_divergence_monitor: directed scenarios plus a
// randomized phase, checked against a cycles-since-arm reference model.
module tb_miter_divergence_monitor;

   localparam int unsigned NCH    = 4;
   localparam int unsigned DW     = 32;
   localparam int unsigned CW     = 8;
   localparam int unsigned SETTLE = 2;
   localparam int          MAXS   = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst, arm, clear;
   logic [NCH-1:0]    ch_mask, vld_a, vld_b;
   logic [DW-1:0]     dat_a [NCH];
   logic [DW-1:0]     dat_b [NCH];
   logic [NCH*DW-1:0] obs_dat_a, obs_dat_b;
   logic              busy, tripped;
   logic [1:0]        trip_ch;
   logic [CW-1:0]     trip_stamp;
   logic [DW-1:0]     trip_dat_a, trip_dat_b;
`ifdef MITER_MON_DIVCNT_EN
   logic [CW-1:0]     div_cnt;
`endif

   always #5 clk = ~clk;

   always_comb begin
      obs_dat_a = '0;
      obs_dat_b = '0;
      for (int i = 0; i < NCH; i++) begin
         obs_dat_a[i*DW +: DW] = dat_a[i];
         obs_dat_b[i*DW +: DW] = dat_b[i];
      end
   end

   miter_divergence_monitor #(
      .NUM_CH(NCH), .CH_W(DW), .CNT_W(CW), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .arm(arm), .clear(clear), .ch_mask(ch_mask),
      .obs_vld_a(vld_a), .obs_dat_a(obs_dat_a),
      .obs_vld_b(vld_b), .obs_dat_b(obs_dat_b),
      .busy(busy), .tripped(tripped), .trip_ch(trip_ch),
      .trip_stamp(trip_stamp), .trip_dat_a(trip_dat_a), .trip_dat_b(trip_dat_b)
`ifdef MITER_MON_DIVCNT_EN
      , .div_cnt(div_cnt)
`endif
   );

   typedef struct {
      int          busy;
      int          tripped;
      int          ch;
      int          stamp;
      logic [31:0] a;
      logic [31:0] b;
      int          dc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: "active" means armed; since = cycles elapsed after arm.
   bit          m_active = 0, m_trip = 0;
   int          m_since = 0, m_ch = 0, m_stamp = 0, m_dc = 0;
   logic [31:0] m_a = '0, m_b = '0;

   function automatic int first_div();
      for (int i = 0; i < NCH; i++) begin
         if (ch_mask[i] && ((vld_a[i] != vld_b[i]) ||
                            (vld_a[i] && vld_b[i] && dat_a[i] != dat_b[i])))
            return i;
      end
      return -1;
   endfunction

   function automatic int sat(input int v);
      return (v > MAXS) ? MAXS : v;
   endfunction

   task automatic cycle();
      int   f;
      exp_t e;
      f = first_div();
      if (rst || clear) begin
         m_active = 0; m_trip = 0; m_since = 0; m_dc = 0;
         m_ch = 0; m_stamp = 0; m_a = '0; m_b = '0;
      end else if (m_trip) begin
         if (f >= 0) m_dc = sat(m_dc + 1);
      end else if (!m_active) begin
         if (arm) begin
            m_active = 1; m_since = 0; m_dc = 0;
         end
      end else begin
         if (m_since >= SETTLE && f >= 0) begin
            m_trip  = 1;
            m_ch    = f;
            m_stamp = sat(m_since);
            m_a     = dat_a[f];
            m_b     = dat_b[f];
            m_dc    = sat(m_dc + 1);
         end
         m_since++;
      end
      e.busy    = (m_active && !m_trip) ? 1 : 0;
      e.tripped = m_trip ? 1 : 0;
      e.ch      = m_ch;
      e.stamp   = m_stamp;
      e.a       = m_a;
      e.b       = m_b;
      e.dc      = m_dc;
      @(posedge clk);
      exp_q.push_back(e);
      #2;
      rst = 0; arm = 0; clear = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy",       32'(busy),       32'(e.busy));
            chk("tripped",    32'(tripped),    32'(e.tripped));
            chk("trip_ch",    32'(trip_ch),    32'(e.ch));
            chk("trip_stamp", 32'(trip_stamp), 32'(e.stamp));
            chk("trip_dat_a", trip_dat_a,      e.a);
            chk("trip_dat_b", trip_dat_b,      e.b);
`ifdef MITER_MON_DIVCNT_EN
            chk("div_cnt",    32'(div_cnt),    32'(e.dc));
`endif
         end
      end
   end

   task automatic set_equal();
      for (int i = 0; i < NCH; i++) begin
         vld_a[i] = 1'($urandom_range(1));
         dat_a[i] = $urandom;
         vld_b[i] = vld_a[i];
         dat_b[i] = dat_a[i];
      end
   endtask

   task automatic inject(input int ch, input int kind);
      logic [31:0] one;
      one = 32'd1;
      case (kind)
         0: begin
            vld_a[ch] = 1'b1; vld_b[ch] = 1'b1;
            dat_b[ch] = dat_a[ch] ^ (one << $urandom_range(31));
         end
         1: begin vld_a[ch] = 1'b1; vld_b[ch] = 1'b0; end
         default: begin vld_a[ch] = 1'b0; vld_b[ch] = 1'b1; end
      endcase
   endtask

   task automatic eq_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         set_equal();
         cycle();
      end
   endtask

   task automatic arm_cycle();
      set_equal(); arm = 1; cycle();
   endtask

   task automatic clear_cycle();
      set_equal(); clear = 1; cycle();
   endtask

   initial begin
      rst = 1; arm = 0; clear = 0; ch_mask = '1;
      set_equal();
      cycle();
      rst = 1; cycle();

      // Mismatches while idle must not trip.
      for (int k = 0; k < 4; k++) begin
         set_equal(); inject(k, k % 3); cycle();
      end

      // Identical streams for 100 cycles.
      arm_cycle();
      eq_cycles(100);
      clear_cycle();

      // Data mismatch on ch2 at stamp 10, then hold with ignored arm and later mismatch.
      arm_cycle();
      eq_cycles(10);
      set_equal();
      vld_a[2] = 1; vld_b[2] = 1; dat_a[2] = 32'h1234; dat_b[2] = 32'h1235;
      cycle();
      for (int k = 0; k < 5; k++) begin
         set_equal(); inject(0, 0); arm = (k == 1); cycle();
      end
      clear_cycle();

      // Simultaneous divergence: ch1 valid-only and ch3 data; later ch0.
      arm_cycle();
      eq_cycles(3);
      set_equal(); inject(1, 1); inject(3, 0); cycle();
      eq_cycles(2);
      set_equal(); inject(0, 0); cycle();
      clear_cycle();

      // Mismatches during settle are ignored; mask suppresses, then enables.
      arm_cycle();
      set_equal(); inject(0, 0); cycle();
      set_equal(); inject(0, 2); cycle();
      set_equal(); inject(0, 0); ch_mask = 4'b1110; cycle();
      ch_mask = '1; cycle();
      eq_cycles(2);
      clear_cycle();

      // Arm ignored mid-monitor; clear wins over a simultaneous divergence.
      arm_cycle();
      eq_cycles(2);
      arm_cycle();
      eq_cycles(2);
      set_equal(); inject(2, 0); clear = 1; cycle();
      eq_cycles(2);
      arm_cycle();
      eq_cycles(3);
      set_equal(); inject(3, 1); cycle();
      eq_cycles(2);

      // Reset mid-trip discards the record.
      rst = 1; set_equal(); cycle();
      eq_cycles(2);

      // Several divergent cycles after the trip, then clear.
      arm_cycle();
      eq_cycles(3);
      for (int k = 0; k < 3; k++) begin
         set_equal(); inject(k, k); cycle();
      end
      eq_cycles(1);
      clear_cycle();

      // Stamp saturation.
      arm_cycle();
      eq_cycles(300);
      set_equal(); inject(1, 0); cycle();
      eq_cycles(2);
      clear_cycle();

      // Randomized phase.
      for (int k = 0; k < 2000; k++) begin
         set_equal();
         if ($urandom_range(99) < 12) inject($urandom_range(NCH - 1), $urandom_range(2));
         if ($urandom_range(99) < 15) ch_mask = 4'($urandom);
         else                         ch_mask = '1;
         arm   = ($urandom_range(99) < 6);
         clear = ($urandom_range(99) < 3);
         rst   = ($urandom_range(99) < 1);
         cycle();
      end

      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/miter_divergence_monitor.md
Name: miter_divergence_monitor

Overview:
- Parametrised observation checker for two-instance miters (instances P1/P2 run with identical public inputs and different secret inputs).
- Compares NUM_CH observable channels of both instances every cycle, e.g. memory request address/valid or commit PC.
- Latches the first divergence: channel, cycle stamp and both data words. The formal flow uses the result as a single assertion target, and simulation uses it as a debug record.

Parameters:
- NUM_CH, 4, number of compared channels (1..32).
- CH_W, 32, data width per channel.
- CNT_W, 16, cycle-stamp counter width.
- SETTLE_CYCLES, 2, cycles after arm during which mismatches are ignored (0..255).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- arm  in  1  pulse; starts monitoring.
- clear  in  1  pulse; returns to IDLE and clears the record.
- ch_mask  in  NUM_CH  per-channel compare enable.
- obs_vld_a  in  NUM_CH  channel valid, instance A.
- obs_dat_a  in  NUM_CH*CH_W  channel data, instance A; channel i is at [i*CH_W +: CH_W].
- obs_vld_b  in  NUM_CH  channel valid, instance B.
- obs_dat_b  in  NUM_CH*CH_W  channel data, instance B.
- busy  out  1  state is SETTLE or MONITOR.
- tripped  out  1  sticky divergence flag.
- trip_ch  out  $clog2(NUM_CH) (min 1)  index of the first diverging channel.
- trip_stamp  out  CNT_W  value of stamp_cnt in the offending cycle.
- trip_dat_a  out  CH_W  instance A data on trip_ch in the offending cycle.
- trip_dat_b  out  CH_W  instance B data on trip_ch in the offending cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE.
  - All outputs 0.
  - stamp_cnt and settle_cnt 0.
- FSM states: IDLE, SETTLE, MONITOR, TRIPPED.
- IDLE:
  - arm with SETTLE_CYCLES>0 -> SETTLE, settle_cnt=SETTLE_CYCLES-1.
  - arm with SETTLE_CYCLES=0 -> MONITOR.
  - stamp_cnt is cleared on arm.
- SETTLE:
  - settle_cnt decrements each cycle; at 0 the FSM goes to MONITOR.
  - Mismatches are ignored.
  - stamp_cnt increments.
- MONITOR:
  - stamp_cnt increments each cycle and saturates at all-ones.
  - Per-channel divergence: div[i] = ch_mask[i] & ((vld_a[i]^vld_b[i]) | (vld_a[i] & vld_b[i] & (dat_a[i]!=dat_b[i]))).
  - Data of channels that are invalid in both instances is never compared.
  - If any div bit is set -> TRIPPED, with the record captured on the same edge:
    - trip_ch = lowest set index.
    - trip_stamp = current stamp_cnt.
    - trip_dat_a and trip_dat_b = the data words of that channel.
  - Latency: tripped rises 1 cycle after the offending input cycle (registered).
- TRIPPED:
  - All outputs hold; arm is ignored.
  - Only clear or rst leaves the state.
- clear (any state):
  - -> IDLE next cycle.
  - Record, tripped and stamp_cnt return to 0.
  - clear has priority over arm and over a simultaneous divergence.
- rst has priority over clear.
- Reset mid-operation discards all state, including a tripped record.
- arm while SETTLE or MONITOR: ignored; it does not restart settle or stamp.
- A mask change takes effect in the same cycle it is applied.
- NUM_CH=1: trip_ch is 1 bit and is always 0.

Optional Feature:
- Macro MITER_MON_DIVCNT_EN.
- When defined:
  - Extra output div_cnt (CNT_W), reset 0.
  - In MONITOR and TRIPPED, div_cnt increments by 1 for every cycle with any div bit set. This includes the trip cycle and cycles after the trip.
  - div_cnt saturates at all-ones and is cleared by clear and on arm.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package miter_mon_pkg:
  - State enum mon_state_e {IDLE, SETTLE, MONITOR, TRIPPED}.
  - Function for channel-index width (max(1,$clog2(n))).
- One sub-module, miter_mon_prio_enc: NUM_CH-bit lowest-set-index priority encoder with an any-set output, purely combinational.
- Comparison and capture muxing stay in the top module.

Test Plan:
- Identical streams, NUM_CH=4, arm then 100 cycles of equal random data and valids -> tripped=0 throughout, busy=1 from the cycle after arm.
- arm; at stamp 10, ch2 dat_a=0x1234 vs dat_b=0x1235, both valid -> next cycle tripped=1, trip_ch=2, trip_stamp=10, trip_dat_a=0x1234, trip_dat_b=0x1235; values held afterwards.
- Simultaneous divergence: ch1 valid-only mismatch (vld_a=1, vld_b=0) and ch3 data mismatch in the same cycle -> trip_ch=1; a later ch0 mismatch leaves the record unchanged.
- Divergence in settle and under mask: SETTLE_CYCLES=2, mismatch on cycles 0-1 after arm -> no trip. Mismatch on ch0 with ch_mask[0]=0 -> no trip. Mask set on the next cycle with the mismatch still present -> trip.
- clear priority: clear in the same cycle as a divergence -> IDLE, tripped=0, record 0. Then arm and a mismatch -> trip with trip_stamp counted from the new arm.
- MITER_MON_DIVCNT_EN: 3 mismatch cycles before clear, trip on the first -> div_cnt=3. stamp_cnt saturation at CNT_W=4 after 20 cycles -> trip_stamp=15.
